// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//
// Elastic pipeline register between two processor stages. The stage holds a
// main entry that drives the outputs and, when PIPE_SKID_EN is defined, a
// second skid entry so that in_ready can be a registered signal with no
// combinational path from out_ready.
//
// Build option:
//   PIPE_SKID_EN defined   : EMPTY/ONE/TWO states, registered in_ready.
//   PIPE_SKID_EN undefined : EMPTY/ONE only,
//                            in_ready = ~out_valid | out_ready.
//
// Parameters:
//   DATA_W  datapath payload width (operands, immediates, PC)
//   CTRL_W  control payload width; reads as zero on bubbles
//   CNT_W   width of the saturating stall counter
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        asynchronous active-low reset
//   flush      synchronous squash of every held entry
//   in_valid   upstream offers an instruction
//   in_ready   this stage accepts in the current cycle
//   in_ctrl    upstream control payload
//   in_data    upstream datapath payload
//   out_valid  downstream payload valid
//   out_ready  downstream accepts in the current cycle
//   out_ctrl   control payload, all-zero whenever out_valid is low
//   out_data   datapath payload, holds its last value while out_valid is low
//   stall_cnt  saturating count of cycles with out_valid & ~out_ready
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
   parameter int DATA_W = 64,
   parameter int CTRL_W = 16,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam logic [1:0] EMPTY = 2'd0;
   localparam logic [1:0] ONE   = 2'd1;
   localparam logic [1:0] TWO   = 2'd2;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [1:0]        state;
   logic [1:0]        state_nxt;
   logic              accept;
   logic              emit;
   logic              load_main_in;
   logic [CTRL_W-1:0] main_ctrl;
   logic [DATA_W-1:0] main_data;

`ifdef PIPE_SKID_EN
   logic              load_main_skid;
   logic              load_skid;
   logic              ready_q;
   logic [CTRL_W-1:0] skid_ctrl;
   logic [DATA_W-1:0] skid_data;
`endif

   assign out_valid = (state != EMPTY);
   assign emit      = out_valid & out_ready;
   assign accept    = in_valid & in_ready & ~flush;

   // Bubbles must look like a NOP downstream, so the control payload is
   // gated rather than left at whatever the main entry last held.
   assign out_ctrl  = out_valid ? main_ctrl : '0;
   assign out_data  = main_data;

`ifdef PIPE_SKID_EN
   assign in_ready  = ready_q;
`else
   // Single-entry mode: a full stage can still take a new entry in the same
   // cycle its current one leaves.
   assign in_ready  = ~out_valid | out_ready;
`endif

   // ---------------------------------------------------------------------------
   // Next-state and load decode
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // through the case statement leaves a signal unassigned (no latch).
      state_nxt      = state;
      load_main_in   = 1'b0;
`ifdef PIPE_SKID_EN
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
`endif
      if (flush) begin
         // Flush wins over any simultaneous accept or emit.
         state_nxt = EMPTY;
      end else begin
         case (state)
            EMPTY: begin
               if (accept) begin
                  state_nxt    = ONE;
                  load_main_in = 1'b1;
               end
            end
            ONE: begin
               if (accept && emit) begin
                  load_main_in = 1'b1;
`ifdef PIPE_SKID_EN
               end else if (accept) begin
                  // Downstream stalled: park the newcomer behind main.
                  state_nxt = TWO;
                  load_skid = 1'b1;
`endif
               end else if (emit) begin
                  state_nxt = EMPTY;
               end
            end
            TWO: begin
`ifdef PIPE_SKID_EN
               // in_ready is low here, so only the skid-to-main move happens.
               if (emit) begin
                  state_nxt      = ONE;
                  load_main_skid = 1'b1;
               end
`else
               state_nxt = EMPTY;
`endif
            end
            default: state_nxt = EMPTY;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of block ordering.
      if (!rst) begin
         state <= EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

`ifdef PIPE_SKID_EN
   // Registered ready: low exactly when the next state holds two entries.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ready_q <= 1'b1;
      end else begin
         ready_q <= (state_nxt != TWO);
      end
   end
`endif

   // ---------------------------------------------------------------------------
   // Payload registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: payload registers are reset too, because out_data is visible
      // while out_valid is low and must read zero straight out of reset.
      if (!rst) begin
         main_ctrl <= '0;
         main_data <= '0;
      end else if (load_main_in) begin
         main_ctrl <= in_ctrl;
         main_data <= in_data;
`ifdef PIPE_SKID_EN
      end else if (load_main_skid) begin
         main_ctrl <= skid_ctrl;
         main_data <= skid_data;
`endif
      end
   end

`ifdef PIPE_SKID_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         skid_ctrl <= '0;
         skid_data <= '0;
      end else if (load_skid) begin
         skid_ctrl <= in_ctrl;
         skid_data <= in_data;
      end
   end
`endif

   // ---------------------------------------------------------------------------
   // Stall counter: saturating, deliberately blind to flush
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt <= '0;
      end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + CNT_ONE;
      end
   end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 64, width of the datapath payload (operands, immediates, PC).
REQ-002 Parameter CTRL_W, default 16, width of the control payload (RegWrt, MemWrt, MemRead, nHalt, ...); forced to zero on bubbles.
REQ-003 Parameter CNT_W, default 16, width of the stall counter.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 flush  in  1  synchronous squash of all held entries (branch mispredict/exception).
REQ-007 in_valid  in  1  upstream stage holds a valid instruction.
REQ-008 in_ready  out  1  this stage accepts in the current cycle.
REQ-009 in_ctrl  in  CTRL_W  upstream control payload.
REQ-010 in_data  in  DATA_W  upstream datapath payload.
REQ-011 out_valid  out  1  downstream payload valid.
REQ-012 out_ready  in  1  downstream accepts in the current cycle.
REQ-013 out_ctrl  out  CTRL_W  control payload; all-zero whenever out_valid=0.
REQ-014 out_data  out  DATA_W  datapath payload.
REQ-015 stall_cnt  out  CNT_W  count of back-pressured cycles.

Function
REQ-016 Accept = in_valid & in_ready & ~flush; emit = out_valid & out_ready.
REQ-017 Storage: main entry (drives outputs) plus skid entry; state machine EMPTY, ONE, TWO.
REQ-018 in_ready SHALL be registered: 1 in EMPTY/ONE, 0 in TWO; no combinational path from out_ready.
REQ-019 EMPTY: accept -> ONE, main<=input; else stay.
REQ-020 ONE: accept&emit -> ONE, main<=input; accept&~emit -> TWO, skid<=input; ~accept&emit -> EMPTY; else hold.
REQ-021 TWO: emit -> ONE, main<=skid; else hold; input never captured in TWO.
REQ-022 out_valid = (state != EMPTY); latency in_valid-accept to out_valid is exactly 1 cycle.
REQ-023 out_ctrl = main ctrl when out_valid else all-zero (bubble is a NOP: no write, no halt).
REQ-024 out_data holds its last value when out_valid=0.
REQ-025 While out_valid & ~out_ready, out_ctrl and out_data SHALL remain stable.
REQ-026 flush: next state EMPTY, in_ready=1, both entries invalidated; flush overrides simultaneous accept and emit; payload offered in flush cycle is dropped.
REQ-027 No entry is ever duplicated or lost absent flush; ordering is strictly FIFO.
REQ-028 stall_cnt increments by 1 each cycle out_valid & ~out_ready; saturates at all-ones; unaffected by flush.

Reset
REQ-029 Assertion of rst (low) SHALL immediately force state EMPTY, out_valid 0, out_ctrl 0, out_data 0, skid entry 0, stall_cnt 0, in_ready 1, regardless of clk.
REQ-030 Reset mid-transfer SHALL discard held entries; first accept is possible on the first rising edge after rst deasserts.

Configuration
REQ-031 Macro PIPE_SKID_EN defined: two-entry skid behaviour of REQ-017..REQ-021 with registered in_ready.
REQ-032 PIPE_SKID_EN undefined: single main entry, states EMPTY/ONE only, in_ready = ~out_valid | out_ready (combinational), TWO unreachable; all other requirements unchanged.

Verification
REQ-033 Reset: drive rst low mid-stream with two entries held -> out_valid 0, out_ctrl 0, stall_cnt 0, in_ready 1 without a clk edge.
REQ-034 Streaming: in_valid=1, out_ready=1, data 0x1..0x8 back-to-back -> out_data 0x1..0x8 one cycle later, no gaps, in_ready constant 1.
REQ-035 Back-pressure (skid on): out_ready=0 while sending 0xA,0xB,0xC -> 0xA and 0xB held, in_ready falls after 0xB, 0xC not accepted; out_ready=1 -> 0xA, 0xB, then 0xC in order; stall_cnt equals stalled cycles.
REQ-036 Flush: state TWO plus in_valid with 0xD and out_ready=1 on flush cycle -> next cycle out_valid 0, out_ctrl 0, in_ready 1; 0xD never emerges.
REQ-037 Bubble: in_valid=0 with in_ctrl=all-ones -> out_ctrl stays 0, out_valid 0.
REQ-038 Saturation with CNT_W=4: hold out_valid&~out_ready for 20 cycles -> stall_cnt stops at 0xF.
